// File: rtl/hlsm_arbiter.sv
// Round-robin scheduler sharing one HLSM compare datapath among N requesters.
// Latches the winner's operands, pulses b for HOLD cycles, returns Do/Eo with a done pulse.
module hlsm_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned HOLD    = 3,
    parameter int unsigned RECOVER = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   Di_req,
    input  logic [N*W-1:0]   Ei_req,
    input  logic [N*W-1:0]   F_req,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [W-1:0]     Do_res,
    output logic [W-1:0]     Eo_res,
    output logic             busy,
    output logic             b_h,
    output logic [W-1:0]     Di_h,
    output logic [W-1:0]     Ei_h,
    output logic [W-1:0]     F_h,
    input  logic [W-1:0]     Do_h,
    input  logic [W-1:0]     Eo_h
);

    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CMAX = (HOLD > RECOVER) ? HOLD : RECOVER;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RECOVER
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   gidx, gidx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [N-1:0]    gnt_nxt, done_nxt;
    logic            b_nxt;
    logic [W-1:0]    di_nxt, ei_nxt, f_nxt, do_nxt, eo_nxt;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cidx;

    // First pending requester at or after ptr, wrapping upward.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cidx       = '0;
        for (int k = 0; k < int'(N); k++) begin
            cidx = IW'((int'(ptr) + k) % int'(N));
            if (!pick_found && req[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            gidx   <= '0;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            b_h    <= 1'b0;
            busy   <= 1'b0;
            Di_h   <= '0;
            Ei_h   <= '0;
            F_h    <= '0;
            Do_res <= '0;
            Eo_res <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gidx   <= gidx_nxt;
            cnt    <= cnt_nxt;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            b_h    <= b_nxt;
            busy   <= (state_nxt != S_IDLE);
            Di_h   <= di_nxt;
            Ei_h   <= ei_nxt;
            F_h    <= f_nxt;
            Do_res <= do_nxt;
            Eo_res <= eo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        b_nxt     = b_h;
        di_nxt    = Di_h;
        ei_nxt    = Ei_h;
        f_nxt     = F_h;
        do_nxt    = Do_res;
        eo_nxt    = Eo_res;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_nxt   = N'(1) << pick_idx;
                    gidx_nxt  = pick_idx;
                    di_nxt    = Di_req[pick_idx*W +: W];
                    ei_nxt    = Ei_req[pick_idx*W +: W];
                    f_nxt     = F_req[pick_idx*W +: W];
                    b_nxt     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cnt == CW'(HOLD - 1)) begin
                    do_nxt    = Do_h;
                    eo_nxt    = Eo_h;
                    done_nxt  = gnt;
                    b_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_RECOVER;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RECOVER: begin
                // Give the HLSM time to settle back to idle before re-arbitrating.
                if (cnt == CW'(RECOVER - 1)) begin
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                    if (gidx == IW'(N - 1)) begin
                        ptr_nxt = '0;
                    end else begin
                        ptr_nxt = gidx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hlsm_arbiter.sv
// Bench for hlsm_arbiter: timeline-based reference model plus directed scenarios.
module tb_hlsm_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 3;
    localparam int R = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] Di_req, Ei_req, F_req;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   Do_res, Eo_res;
    logic           busy, b_h;
    logic [W-1:0]   Di_h, Ei_h, F_h;
    logic [W-1:0]   hl_do, hl_eo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hlsm_arbiter #(.N(N), .W(W), .HOLD(H), .RECOVER(R)) dut (
        .clk(clk), .rst(rst), .req(req),
        .Di_req(Di_req), .Ei_req(Ei_req), .F_req(F_req),
        .gnt(gnt), .done(done), .Do_res(Do_res), .Eo_res(Eo_res),
        .busy(busy), .b_h(b_h), .Di_h(Di_h), .Ei_h(Ei_h), .F_h(F_h),
        .Do_h(hl_do), .Eo_h(hl_eo)
    );

    // HLSM compare rule: pass D/E through when D+E fits within F, otherwise report zero.
    function automatic logic [2*W-1:0] hlsm_fn(input logic [W-1:0] d, e, f);
        logic [W:0] s;
        s = {1'b0, d} + {1'b0, e};
        if (s <= {1'b0, f}) return {d, e};
        return '0;
    endfunction

    // Stand-in for the HLSM: output is only meaningful while b is held high.
    always @(posedge clk) begin
        if (rst || !b_h) begin
            hl_do <= '0;
            hl_eo <= '0;
        end else begin
            {hl_do, hl_eo} <= hlsm_fn(Di_h, Ei_h, F_h);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is described by its grant edge; outputs follow from elapsed edges.
    int           cyc = 0;
    bit           m_active = 0;
    int           m_g = 0, m_gcyc = 0, m_ptr = 0;
    logic [W-1:0] m_di = '0, m_ei = '0, m_f = '0, m_do = '0, m_eo = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 0; m_ptr = 0; m_g = 0;
            m_di = '0; m_ei = '0; m_f = '0; m_do = '0; m_eo = '0;
        end else begin
            if (m_active && cyc == m_gcyc + H + R) begin
                m_active = 0;
                m_ptr = (m_g + 1) % N;
            end else if (!m_active && req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                m_active = 1;
                m_gcyc = cyc;
                m_di = Di_req[m_g*W +: W];
                m_ei = Ei_req[m_g*W +: W];
                m_f  = F_req[m_g*W +: W];
            end
            if (m_active && cyc == m_gcyc + H)
                {m_do, m_eo} = hlsm_fn(m_di, m_ei, m_f);
        end
    end

    bit cmp_en = 1'b1;
    always @(negedge clk) begin
        logic [N-1:0] oh;
        int k;
        if (cmp_en) begin
            oh = '0;
            oh[m_g] = 1'b1;
            k = cyc - m_gcyc;
            check("m_gnt",  32'(gnt),  m_active ? 32'(oh) : 32'd0);
            check("m_done", 32'(done), (m_active && k == H) ? 32'(oh) : 32'd0);
            check("m_b_h",  32'(b_h),  32'(m_active && k < H));
            check("m_busy", 32'(busy), 32'(m_active));
            check("m_di_h", 32'(Di_h), 32'(m_di));
            check("m_ei_h", 32'(Ei_h), 32'(m_ei));
            check("m_f_h",  32'(F_h),  32'(m_f));
            check("m_do",   32'(Do_res), 32'(m_do));
            check("m_eo",   32'(Eo_res), 32'(m_eo));
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] d, e, f);
        Di_req[i*W +: W] = d;
        Ei_req[i*W +: W] = e;
        F_req[i*W +: W]  = f;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 30);
        check("gnt_seen", 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_done(inout int n);
        int t;
        t = 0;
        while (done == '0 && t < 30) begin
            @(negedge clk);
            n++;
            t++;
        end
        check("done_seen", 32'(done != '0), 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, hi, lo, bad, cnt;
        int order[$];
        int rises[$];
        logic [N-1:0] prev, sdone;
        logic [W-1:0] sdo, seo;
        int exp_order[5];
        exp_order = '{0, 1, 3, 0, 1};

        rst = 1'b1; req = '0; Di_req = '0; Ei_req = '0; F_req = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_do", 32'(Do_res), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single job, result passed through.
        set_op(0, 4'd2, 4'd4, 4'd6);
        req = 4'b0001;
        wait_gnt(n);
        req = '0;
        check("t1_gnt", 32'(gnt), 32'b0001);
        wait_done(n);
        check("t1_latency", 32'(n), 32'(H + 1));
        check("t1_done", 32'(done), 32'b0001);
        check("t1_do", 32'(Do_res), 32'd2);
        check("t1_eo", 32'(Eo_res), 32'd4);
        wait_idle();

        // No request: everything quiet, results held.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_h || gnt != '0 || done != '0 || busy) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_do_hold", 32'(Do_res), 32'd2);
        check("idle_eo_hold", 32'(Eo_res), 32'd4);

        // Single job, zero result; b_h profile.
        set_op(2, 4'd2, 4'd4, 4'd2);
        req = 4'b0100;
        wait_gnt(n);
        req = '0;
        hi = 0; lo = 0; sdone = '0; sdo = 4'hf; seo = 4'hf; cnt = 0;
        while (busy && cnt < 20) begin
            if (b_h) hi++; else lo++;
            if (done != '0) begin sdone = done; sdo = Do_res; seo = Eo_res; end
            @(negedge clk);
            cnt++;
        end
        check("t2_bh_high", 32'(hi), 32'(H));
        check("t2_bh_low", 32'(lo), 32'(R));
        check("t2_done", 32'(sdone), 32'b0100);
        check("t2_do", 32'(sdo), 32'd0);
        check("t2_eo", 32'(seo), 32'd0);

        // Contention from reset.
        rst = 1'b1; req = 4'b1011;
        set_op(0, 4'd1, 4'd1, 4'd5);
        set_op(1, 4'd3, 4'd3, 4'd5);
        set_op(3, 4'd2, 4'd2, 4'd7);
        @(negedge clk);
        rst = 1'b0;
        prev = '0; cnt = 0;
        while (order.size() < 5 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (gnt != '0 && prev == '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
                rises.push_back(cnt);
            end
            prev = gnt;
        end
        check("t3_rises", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("t3_order", 32'(order[i]), 32'(exp_order[i]));
        for (int i = 1; i < rises.size(); i++)
            check("t3_spacing", 32'(rises[i] - rises[i-1]), 32'(H + R + 1));
        req = '0;
        wait_idle();
        @(negedge clk);

        // Operand change during LAUNCH does not affect the job.
        set_op(0, 4'd2, 4'd4, 4'd6);
        req = 4'b0001;
        wait_gnt(n);
        req = '0;
        set_op(0, 4'd2, 4'd4, 4'd2);
        @(negedge clk);
        n++;
        check("t5_f_h", 32'(F_h), 32'd6);
        wait_done(n);
        check("t5_do", 32'(Do_res), 32'd2);
        check("t5_eo", 32'(Eo_res), 32'd4);
        wait_idle();
        @(negedge clk);

        // Reset in the second LAUNCH cycle drops the job.
        set_op(0, 4'd1, 4'd2, 4'd9);
        req = 4'b0001;
        wait_gnt(n);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_b_h", 32'(b_h), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_do", 32'(Do_res), 32'd0);
        check("t6_f_h", 32'(F_h), 32'd0);
        rst = 1'b0;
        wait_gnt(n);
        check("t6_regrant", 32'(gnt), 32'b0010);
        req = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
